// File: rtl/bf_defs.sv
// bf_defs: opcode constants, sequencer state encoding and default pointer sizing
package bf_defs;
    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_INC   = 3'd1;
    localparam logic [2:0] OP_DEC   = 3'd2;
    localparam logic [2:0] OP_RIGHT = 3'd3;
    localparam logic [2:0] OP_LEFT  = 3'd4;
    localparam logic [2:0] OP_OUT   = 3'd5;
    localparam logic [2:0] OP_IN    = 3'd6;
    localparam logic [2:0] OP_FLUSH = 3'd7;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXEC,
        ST_STORE,
        ST_MOVE
    } state_t;
    localparam int DEF_ADDRESS_WIDTH = 16;
    localparam int DEF_MAX_ADDRESS   = 29999;
endpackage

// File: rtl/ptr_counter.sv
// ptr_counter: up/down data pointer that wraps between 0 and MAX
module ptr_counter #(
    parameter int WIDTH = 16,
    parameter int MAX   = 29999
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_up,
    output logic [WIDTH-1:0] o_count
);
    localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MAX);
    logic [WIDTH-1:0] r_count;
    assign o_count = r_count;
    // step the pointer one cell when enabled, wrapping at either end
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_count <= '0;
        else if (i_en)
            r_count <= i_up ? ((r_count == L_MAX) ? '0 : r_count + 1'b1)
                            : ((r_count == '0) ? L_MAX : r_count - 1'b1);
    end
endmodule

// File: rtl/data_sequencer.sv
// data_sequencer: turns data opcodes into data-line strobes, caching one cell in the counter
module data_sequencer
    import bf_defs::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int MAX_ADDRESS   = DEF_MAX_ADDRESS
) (
    input  logic                     CLOCK,
    input  logic                     RST,
    input  logic                     OP_VALID,
    input  logic [2:0]               OP_CODE,
    output logic                     OP_READY,
    output logic [ADDRESS_WIDTH-1:0] ADDRESS,
    output logic                     LOAD,
    output logic                     STORE,
    output logic                     INC,
    output logic                     DEC,
    output logic                     IN,
    output logic                     OUT,
    output logic                     DIRTY
);
    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_op;
    logic       r_cvalid;
    logic       r_dirty;
    logic       w_accept;
    assign OP_READY = (r_state == ST_IDLE) && !RST;
    assign w_accept = OP_VALID && OP_READY;
    assign LOAD     = r_state == ST_LOAD;
    assign STORE    = r_state == ST_STORE;
    assign INC      = (r_state == ST_EXEC) && (r_op == OP_INC);
    assign DEC      = (r_state == ST_EXEC) && (r_op == OP_DEC);
    assign IN       = (r_state == ST_EXEC) && (r_op == OP_IN);
    assign OUT      = (r_state == ST_EXEC) && (r_op == OP_OUT);
    assign DIRTY    = r_dirty;
    ptr_counter #(
        .WIDTH(ADDRESS_WIDTH),
        .MAX  (MAX_ADDRESS)
    ) u_ptr (
        .i_clk  (CLOCK),
        .i_rst  (RST),
        .i_en   (r_state == ST_MOVE),
        .i_up   (r_op == OP_RIGHT),
        .o_count(ADDRESS)
    );
    // state register
    always_ff @(posedge CLOCK) begin
        if (RST)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end
    // next state: skip LOAD on a cache hit, skip STORE when the counter is clean
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (OP_CODE)
                        OP_NOP:                 w_next = ST_IDLE;
                        OP_INC, OP_DEC, OP_OUT: w_next = r_cvalid ? ST_EXEC : ST_LOAD;
                        OP_IN:                  w_next = ST_EXEC;
                        OP_RIGHT, OP_LEFT:      w_next = r_dirty ? ST_STORE : ST_MOVE;
                        OP_FLUSH:               w_next = r_dirty ? ST_STORE : ST_EXEC;
                        default:                w_next = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD:  w_next = ST_EXEC;
            ST_EXEC:  w_next = ST_IDLE;
            ST_STORE: w_next = (r_op == OP_FLUSH) ? ST_IDLE : ST_MOVE;
            ST_MOVE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end
    // latched opcode and cache flags, updated as each phase completes
    always_ff @(posedge CLOCK) begin
        if (RST) begin
            r_op     <= OP_NOP;
            r_cvalid <= 1'b0;
            r_dirty  <= 1'b0;
        end else begin
            if (w_accept)
                r_op <= OP_CODE;
            case (r_state)
                ST_LOAD:  r_cvalid <= 1'b1;
                ST_EXEC: begin
                    if (r_op == OP_INC || r_op == OP_DEC || r_op == OP_IN) begin
                        r_cvalid <= 1'b1;
                        r_dirty  <= 1'b1;
                    end
                end
                ST_STORE: r_dirty <= 1'b0;
                ST_MOVE: begin
                    r_cvalid <= 1'b0;
                    r_dirty  <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_data_sequencer.sv
// tb_data_sequencer: scoreboard bench with an operation-level reference model
module tb_data_sequencer;
    import bf_defs::*;
    localparam int MAXA = 29999;
    localparam logic [5:0] E_LOAD  = 6'b000001;
    localparam logic [5:0] E_STORE = 6'b000010;
    localparam logic [5:0] E_INC   = 6'b000100;
    localparam logic [5:0] E_DEC   = 6'b001000;
    localparam logic [5:0] E_IN    = 6'b010000;
    localparam logic [5:0] E_OUT   = 6'b100000;
    logic        CLOCK = 0;
    logic        RST = 1;
    logic        OP_VALID = 0;
    logic [2:0]  OP_CODE = 0;
    logic        OP_READY;
    logic [15:0] ADDRESS;
    logic        LOAD, STORE, INC, DEC, IN, OUT, DIRTY;
    logic [5:0]  strobes;
    typedef struct {
        logic [5:0] s;
        int         a;
    } ev_t;
    ev_t q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  m_ptr = 0;
    int  m_busy = 0;
    bit  m_cv = 0;
    bit  m_dirty = 0;
    bit  acc;
    int  n_acc;
    assign strobes = {OUT, IN, DEC, INC, STORE, LOAD};
    always #5 CLOCK = ~CLOCK;
    data_sequencer #(
        .ADDRESS_WIDTH(16),
        .MAX_ADDRESS  (MAXA)
    ) dut (
        .CLOCK   (CLOCK),
        .RST     (RST),
        .OP_VALID(OP_VALID),
        .OP_CODE (OP_CODE),
        .OP_READY(OP_READY),
        .ADDRESS (ADDRESS),
        .LOAD    (LOAD),
        .STORE   (STORE),
        .INC     (INC),
        .DEC     (DEC),
        .IN      (IN),
        .OUT     (OUT),
        .DIRTY   (DIRTY)
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    // one expected busy cycle: strobe pattern and the address visible during it
    function automatic void push(input logic [5:0] s);
        q.push_back('{s, m_ptr});
        m_busy++;
    endfunction
    // reference model: what one accepted opcode costs, from the cache rules
    function automatic void model_accept(input logic [2:0] c);
        case (c)
            OP_INC, OP_DEC, OP_OUT: begin
                if (!m_cv) push(E_LOAD);
                push(c == OP_INC ? E_INC : c == OP_DEC ? E_DEC : E_OUT);
                m_cv = 1;
                if (c != OP_OUT) m_dirty = 1;
            end
            OP_IN: begin
                push(E_IN);
                m_cv = 1;
                m_dirty = 1;
            end
            OP_RIGHT, OP_LEFT: begin
                if (m_dirty) push(E_STORE);
                push(6'b0);
                if (c == OP_RIGHT) m_ptr = (m_ptr == MAXA) ? 0 : m_ptr + 1;
                else m_ptr = (m_ptr == 0) ? MAXA : m_ptr - 1;
                m_cv = 0;
                m_dirty = 0;
            end
            OP_FLUSH: begin
                if (m_dirty) push(E_STORE);
                else push(6'b0);
                m_dirty = 0;
            end
            default: ;
        endcase
    endfunction
    // monitor: every busy or strobing cycle must match the next expected entry
    always @(negedge CLOCK) begin : monitor
        ev_t e;
        if (RST === 1'b0 && (strobes !== 6'b0 || OP_READY !== 1'b1)) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_busy: strobes %b ready %b, required idle", strobes, OP_READY);
            end else begin
                e = q.pop_front();
                check("strobes", strobes, e.s);
                check("busy_addr", ADDRESS, e.a);
            end
        end
    end
    task automatic cycle(input logic v, input logic [2:0] c, output bit a);
        bit exp_ready;
        @(posedge CLOCK);
        #1;
        OP_VALID = v;
        OP_CODE = c;
        @(negedge CLOCK);
        exp_ready = (m_busy == 0) && !RST;
        if (m_busy > 0) m_busy--;
        check("ready", OP_READY, exp_ready);
        if (exp_ready) begin
            check("addr", ADDRESS, m_ptr);
            check("dirty", DIRTY, m_dirty);
        end
        a = exp_ready && v;
        if (a) model_accept(c);
    endtask
    task automatic issue(input logic [2:0] c);
        bit a = 0;
        for (int i = 0; i < 8 && !a; i++) cycle(1'b1, c, a);
        if (!a) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: opcode %0d not accepted within 8 cycles", c);
        end
    endtask
    task automatic idle(input int n);
        bit a;
        repeat (n) cycle(1'b0, OP_NOP, a);
    endtask
    task automatic do_reset(input int n);
        @(posedge CLOCK);
        #1;
        RST = 1;
        OP_VALID = 0;
        q.delete();
        m_ptr = 0;
        m_cv = 0;
        m_dirty = 0;
        m_busy = 0;
        @(negedge CLOCK);
        check("rst_ready", OP_READY, 0);
        repeat (n) begin
            @(negedge CLOCK);
            check("rst_ready", OP_READY, 0);
            check("rst_strobes", strobes, 0);
            check("rst_addr", ADDRESS, 0);
            check("rst_dirty", DIRTY, 0);
        end
        @(posedge CLOCK);
        #1;
        RST = 0;
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        do_reset(2);
        issue(OP_INC);
        issue(OP_INC);
        issue(OP_INC);
        issue(OP_OUT);
        idle(3);
        check("seq1_addr", ADDRESS, 0);
        check("seq1_dirty", DIRTY, 1);
        issue(OP_INC);
        issue(OP_RIGHT);
        idle(3);
        check("right_addr", ADDRESS, 1);
        check("right_dirty", DIRTY, 0);
        issue(OP_OUT);
        idle(3);
        do_reset(1);
        issue(OP_LEFT);
        idle(2);
        check("left_wrap", ADDRESS, MAXA);
        issue(OP_RIGHT);
        idle(2);
        check("right_wrap", ADDRESS, 0);
        do_reset(1);
        issue(OP_IN);
        issue(OP_OUT);
        issue(OP_FLUSH);
        idle(2);
        check("flush_dirty", DIRTY, 0);
        issue(OP_FLUSH);
        idle(2);
        cycle(1'b1, OP_INC, acc);
        for (int i = 0; i < 40; i++) cycle(1'b1, 3'($urandom_range(0, 7)), acc);
        idle(4);
        n_acc = 0;
        repeat (10) begin
            cycle(1'b1, OP_NOP, acc);
            n_acc += int'(acc);
        end
        check("nop_stream", n_acc, 10);
        do_reset(1);
        issue(OP_INC);
        issue(OP_RIGHT);
        do_reset(2);
        issue(OP_OUT);
        idle(3);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset(1);
            else cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), acc);
        end
        idle(4);
        check("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
